// File: rtl/ahb_rr_arbiter.sv
// AHB bus arbiter: round-robin or fixed-priority grant with lock hold and split masking.
// Optional split support is compiled in with `define AHB_ARB_SPLIT_EN.
module ahb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS    = 16,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned RR_MODE        = 1
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQx,
  input  logic [NUM_MASTERS-1:0] HLOCKx,
  input  logic [NUM_MASTERS-1:0] HSPLIT,
  input  logic [1:0]             HRESP,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANTx,
  output logic [3:0]             HMASTER,
  output logic                   HMASTLOCK
);

  localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IW-1:0] DEF_IDX = IW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  logic [IW-1:0]          gnt_idx;
  logic [IW-1:0]          mst_idx;
  logic [IW-1:0]          last_winner;
  logic [NUM_MASTERS-1:0] split_mask;
  logic [NUM_MASTERS-1:0] eligible;
  logic [IW-1:0]          win_idx;
  logic [IW-1:0]          ci;
  logic                   win_found;
  logic                   arb_en;

  // k-th candidate in search order; round-robin starts just past the last winner
  function automatic logic [IW-1:0] cand(input logic [IW-1:0] lw, input int unsigned k);
    int unsigned c;
    c = (RR_MODE != 0) ? 32'(lw) + 32'd1 + k : k;
    if (c >= NUM_MASTERS) c = c - NUM_MASTERS;
    return IW'(c);
  endfunction

  assign eligible = HBUSREQx & ~split_mask;
  // A split-masked owner loses its lock hold so the bus can move on
  assign arb_en   = HREADY && (!HLOCKx[gnt_idx] || split_mask[gnt_idx]);
  assign HMASTER  = 4'(mst_idx);

  always_comb begin
    win_found = 1'b0;
    win_idx   = DEF_IDX;
    ci        = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      ci = cand(last_winner, k);
      if (!win_found && eligible[ci]) begin
        win_found = 1'b1;
        win_idx   = ci;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HGRANTx     <= DEF_GNT;
      gnt_idx     <= DEF_IDX;
      mst_idx     <= DEF_IDX;
      HMASTLOCK   <= 1'b0;
      last_winner <= DEF_IDX;
    end else begin
      if (arb_en) begin
        HGRANTx <= NUM_MASTERS'(1) << win_idx;
        gnt_idx <= win_idx;
        if (win_found) last_winner <= win_idx;
      end
      // Address phase follows the grant by one ready cycle
      if (HREADY) begin
        mst_idx   <= gnt_idx;
        HMASTLOCK <= HLOCKx[gnt_idx];
      end
    end
  end

`ifdef AHB_ARB_SPLIT_EN
  logic [NUM_MASTERS-1:0] split_set;

  assign split_set = (HRESP == RESP_SPLIT && !HREADY) ? NUM_MASTERS'(1) << mst_idx
                                                      : '0;

  // Set is ORed in after the clear so a same-cycle set wins
  always_ff @(posedge HCLK) begin
    if (HRESET) split_mask <= '0;
    else        split_mask <= (split_mask & ~HSPLIT) | split_set;
  end
`else
  logic unused_split;

  assign split_mask   = '0;
  assign unused_split = ^{HSPLIT, HRESP, RESP_SPLIT};
`endif

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Scoreboard bench for ahb_rr_arbiter: a round-robin instance (default 0) and a
// fixed-priority instance (default 2) share stimulus; expectations are hand-computed.
module tb_ahb_rr_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] HBUSREQx, HLOCKx, HSPLIT;
  logic [1:0] HRESP;
  logic       HREADY;
  logic [3:0] g_rr, g_fp, m_rr, m_fp;
  logic       l_rr, l_fp;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  typedef struct {
    string       nm;
    int unsigned cyc;
    bit          fp;
    logic [3:0]  gnt;
    logic [3:0]  mst;
    logic        lck;
  } exp_t;

  exp_t sb[$];

  ahb_rr_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0), .RR_MODE(1)) u_rr (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx),
    .HSPLIT(HSPLIT), .HRESP(HRESP), .HREADY(HREADY),
    .HGRANTx(g_rr), .HMASTER(m_rr), .HMASTLOCK(l_rr));

  ahb_rr_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(2), .RR_MODE(0)) u_fp (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx),
    .HSPLIT(HSPLIT), .HRESP(HRESP), .HREADY(HREADY),
    .HGRANTx(g_fp), .HMASTER(m_fp), .HMASTLOCK(l_fp));

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  a_oh_rr: assert property (@(posedge HCLK) disable iff (HRESET) $onehot(g_rr))
    else begin n_fail++; $error("FAIL onehot_rr got=%b", g_rr); end
  a_oh_fp: assert property (@(posedge HCLK) disable iff (HRESET) $onehot(g_fp))
    else begin n_fail++; $error("FAIL onehot_fp got=%b", g_fp); end
  a_st_rr: assert property (@(posedge HCLK) disable iff (HRESET) !HREADY |=> $stable(g_rr))
    else begin n_fail++; $error("FAIL stable_rr got=%b", g_rr); end
  a_st_fp: assert property (@(posedge HCLK) disable iff (HRESET) !HREADY |=> $stable(g_fp))
    else begin n_fail++; $error("FAIL stable_fp got=%b", g_fp); end

  // Monitor: compares every expectation tagged for the cycle just registered
  always @(negedge HCLK) begin
    exp_t       e;
    logic [3:0] ag, am;
    logic       al;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      ag = e.fp ? g_fp : g_rr;
      am = e.fp ? m_fp : m_rr;
      al = e.fp ? l_fp : l_rr;
      n_cmp++;
      if (e.cyc != cyc || ag !== e.gnt || am !== e.mst || al !== e.lck) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: got gnt=%b mst=%0d lck=%b, want gnt=%b mst=%0d lck=%b (cyc %0d)",
                 e.nm, cyc, ag, am, al, e.gnt, e.mst, e.lck, e.cyc);
      end
    end
  end

  task automatic exp_push(input string nm, input bit fp, input logic [3:0] g,
                          input logic [3:0] m, input logic l);
    exp_t e;
    e.nm = nm; e.cyc = cyc + 1; e.fp = fp; e.gnt = g; e.mst = m; e.lck = l;
    sb.push_back(e);
  endtask

  task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                      input logic [3:0] spl, input logic [1:0] resp, input logic rdy);
    HRESET = rst; HBUSREQx = req; HLOCKx = lock; HSPLIT = spl; HRESP = resp; HREADY = rdy;
    @(posedge HCLK);
    #1;
  endtask

  logic [3:0] seq_a [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                            4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    step(1, 4'b0000, 4'b0000, 4'b0000, 2'b00, 1);
    exp_push("rst_rr", 0, 4'b0001, 4'd0, 0);
    exp_push("rst_fp", 1, 4'b0100, 4'd2, 0);
    step(1, 4'b0000, 4'b0000, 4'b0000, 2'b00, 1);

    // All requesting: rotation 1,2,3,0 from reset default 0
    for (int i = 0; i < 8; i++) begin
      exp_push($sformatf("rr_seq%0d", i), 0, seq_a[i], 4'(i % 4), 0);
      if (i == 0) exp_push("fp_all0", 1, 4'b0001, 4'd2, 0);
      if (i == 1) exp_push("fp_all1", 1, 4'b0001, 4'd0, 0);
      step(0, 4'b1111, 4'b0000, 4'b0000, 2'b00, 1);
    end

    // Sparse requests 1010 then 1000
    exp_push("fp_1010a", 1, 4'b0010, 4'd0, 0); exp_push("rr_1010a", 0, 4'b0010, 4'd0, 0);
    step(0, 4'b1010, 4'b0000, 4'b0000, 2'b00, 1);
    exp_push("fp_1010b", 1, 4'b0010, 4'd1, 0); exp_push("rr_1010b", 0, 4'b1000, 4'd1, 0);
    step(0, 4'b1010, 4'b0000, 4'b0000, 2'b00, 1);
    exp_push("fp_1010c", 1, 4'b0010, 4'd1, 0); exp_push("rr_1010c", 0, 4'b0010, 4'd3, 0);
    step(0, 4'b1010, 4'b0000, 4'b0000, 2'b00, 1);
    exp_push("fp_1000", 1, 4'b1000, 4'd1, 0);  exp_push("rr_1000", 0, 4'b1000, 4'd1, 0);
    step(0, 4'b1000, 4'b0000, 4'b0000, 2'b00, 1);

    // Locked master 2 holds the bus against master 3
    exp_push("lk_gnt2", 0, 4'b0100, 4'd3, 0);
    step(0, 4'b0100, 4'b0000, 4'b0000, 2'b00, 1);
    for (int i = 0; i < 5; i++) begin
      exp_push($sformatf("lk_hold%0d", i), 0, 4'b0100, 4'd2, 1);
      step(0, 4'b1100, 4'b0100, 4'b0000, 2'b00, 1);
    end
    exp_push("lk_release", 0, 4'b1000, 4'd2, 0);
    step(0, 4'b1100, 4'b0000, 4'b0000, 2'b00, 1);

    // Wait states freeze grant and address-phase owner
    exp_push("wait0", 0, 4'b1000, 4'd2, 0);
    step(0, 4'b0001, 4'b0000, 4'b0000, 2'b00, 0);
    exp_push("wait1", 0, 4'b1000, 4'd2, 0);
    step(0, 4'b0001, 4'b0000, 4'b0000, 2'b00, 0);
    exp_push("wait_done", 0, 4'b0001, 4'd3, 0);
    step(0, 4'b0001, 4'b0000, 4'b0000, 2'b00, 1);

    // Split sequence on master 1, then default grant keeps last_winner
    exp_push("rst2_rr", 0, 4'b0001, 4'd0, 0);
    step(1, 4'b0000, 4'b0000, 4'b0000, 2'b00, 1);
    exp_push("sp_e1", 0, 4'b0010, 4'd0, 0);
    step(0, 4'b0010, 4'b0000, 4'b0000, 2'b00, 1);
    exp_push("sp_e2", 0, 4'b0010, 4'd1, 0);
    step(0, 4'b0010, 4'b0000, 4'b0000, 2'b00, 1);
    exp_push("sp_e3", 0, 4'b0010, 4'd1, 0);
    step(0, 4'b0010, 4'b0000, 4'b0010, 2'b11, 0);
`ifdef AHB_ARB_SPLIT_EN
    exp_push("sp_e4", 0, 4'b0100, 4'd1, 1);
    step(0, 4'b0110, 4'b0010, 4'b0000, 2'b11, 1);
    exp_push("sp_e5", 0, 4'b0001, 4'd2, 0);
    step(0, 4'b0010, 4'b0000, 4'b0000, 2'b00, 1);
    exp_push("sp_e6", 0, 4'b0001, 4'd0, 0);
    step(0, 4'b0010, 4'b0000, 4'b0010, 2'b00, 1);
    exp_push("sp_e7", 0, 4'b0010, 4'd0, 0);
    step(0, 4'b0010, 4'b0000, 4'b0000, 2'b00, 1);
`else
    exp_push("sp_e4", 0, 4'b0010, 4'd1, 1);
    step(0, 4'b0110, 4'b0010, 4'b0000, 2'b11, 1);
    exp_push("sp_e5", 0, 4'b0010, 4'd1, 0);
    step(0, 4'b0010, 4'b0000, 4'b0000, 2'b00, 1);
    exp_push("sp_e6", 0, 4'b0010, 4'd1, 0);
    step(0, 4'b0010, 4'b0000, 4'b0010, 2'b00, 1);
    exp_push("sp_e7", 0, 4'b0010, 4'd1, 0);
    step(0, 4'b0010, 4'b0000, 4'b0000, 2'b00, 1);
`endif
    exp_push("dflt_idle", 0, 4'b0001, 4'd1, 0);
    step(0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 1);
    exp_push("dflt_keep_lw", 0, 4'b0100, 4'd0, 0);
    step(0, 4'b1111, 4'b0000, 4'b0000, 2'b00, 1);

    // Default master 2 on idle bus, reset in the middle of a lock
    exp_push("rst3_fp", 1, 4'b0100, 4'd2, 0);
    step(1, 4'b0000, 4'b0000, 4'b0000, 2'b00, 1);
    exp_push("fp_idle", 1, 4'b0100, 4'd2, 0);
    step(0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 1);
    exp_push("fp_lk0", 1, 4'b0001, 4'd2, 0);
    step(0, 4'b0001, 4'b0001, 4'b0000, 2'b00, 1);
    exp_push("fp_lk1", 1, 4'b0001, 4'd0, 1);
    step(0, 4'b0001, 4'b0001, 4'b0000, 2'b00, 1);
    exp_push("fp_lk2", 1, 4'b0001, 4'd0, 1);
    step(0, 4'b0001, 4'b0001, 4'b0000, 2'b00, 1);
    exp_push("fp_rst_lk", 1, 4'b0100, 4'd2, 0);
    exp_push("rr_rst_lk", 0, 4'b0001, 4'd0, 0);
    step(1, 4'b0001, 4'b0001, 4'b0000, 2'b00, 1);
    exp_push("fp_post_rst", 1, 4'b0100, 4'd2, 0);
    step(0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 1);

    step(0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 1);
    step(0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 1);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_rr_arbiter.md
AHB_RR_ARBITER -- requirements
Module: ahb_rr_arbiter

Interface
- REQ-001: Parameter NUM_MASTERS, default 16: number of bus masters, legal range 2..16.
- REQ-002: Parameter DEFAULT_MASTER, default 0: master granted when no eligible request exists, legal range 0..NUM_MASTERS-1.
- REQ-003: Parameter RR_MODE, default 1: 1 selects round-robin, 0 selects fixed priority where the lowest index wins.
- REQ-004: HCLK  in  1  single clock, all state updates on rising edge.
- REQ-005: HRESET  in  1  synchronous, active-high reset.
- REQ-006: HBUSREQx  in  NUM_MASTERS  per-master bus request.
- REQ-007: HLOCKx  in  NUM_MASTERS  per-master locked-transfer request.
- REQ-008: HSPLIT  in  NUM_MASTERS  per-master split-resume strobe from slaves.
- REQ-009: HRESP  in  2  current slave response; 2'b11 = SPLIT.
- REQ-010: HREADY  in  1  transfer-complete qualifier.
- REQ-011: HGRANTx  out  NUM_MASTERS  one-hot registered grant.
- REQ-012: HMASTER  out  4  index of the master owning the address phase; upper bits are zero when NUM_MASTERS < 16.
- REQ-013: HMASTLOCK  out  1  current address phase is locked.

Function
- REQ-014: HGRANTx SHALL be exactly one-hot on every cycle after reset.
- REQ-015: Eligible set SHALL be HBUSREQx & ~split_mask.
- REQ-016: Arbitration SHALL occur only on cycles with HREADY=1 and the granted master's HLOCKx=0; the new grant appears on HGRANTx on the following cycle.
- REQ-017: While HREADY=0, or while the granted master holds HLOCKx=1, HGRANTx SHALL hold its value.
- REQ-018: With RR_MODE=1, the search SHALL start at last_winner+1 and wrap from NUM_MASTERS-1 to 0; the current owner has the lowest priority.
- REQ-019: last_winner SHALL update only when a requesting master wins; a default grant with no request SHALL leave it unchanged.
- REQ-020: With RR_MODE=0, the lowest-index eligible master SHALL win.
- REQ-021: With an empty eligible set, HGRANTx SHALL select DEFAULT_MASTER, even if DEFAULT_MASTER is split-masked.
- REQ-022: On a cycle with HREADY=1, HMASTER SHALL load the index of the currently granted master (one-cycle address-phase handover); it holds otherwise.
- REQ-023: On a cycle with HREADY=1, HMASTLOCK SHALL load HLOCKx[granted index]; it holds otherwise.
- REQ-024: Split: HRESP=2'b11 with HREADY=0 SHALL set split_mask[HMASTER] on the next cycle.
- REQ-025: Split: HSPLIT[i]=1 SHALL clear split_mask[i] on the next cycle.
- REQ-026: When a split set and an HSPLIT clear hit the same bit in the same cycle, the set SHALL win.
- REQ-027: When the granted master becomes split-masked, the grant SHALL move on the next HREADY=1 cycle, even if HLOCKx is asserted.

Reset
- REQ-028: HRESET=1 at a clock edge SHALL force HGRANTx to the one-hot of DEFAULT_MASTER, HMASTER=DEFAULT_MASTER, HMASTLOCK=0, split_mask=0 and last_winner=DEFAULT_MASTER.
- REQ-029: HRESET SHALL override every in-flight lock, split or arbitration in the same cycle.

Configuration
- REQ-030: Macro AHB_ARB_SPLIT_EN defined: split masking per REQ-024..027 is compiled in.
- REQ-031: Macro AHB_ARB_SPLIT_EN undefined: split_mask is constant 0 and HSPLIT/HRESP are ignored.

Verification
- REQ-032: NUM_MASTERS=4, RR_MODE=1, HREADY=1, HBUSREQx=4'b1111 held for 8 cycles -> grant sequence 1,2,3,0,1,2,3,0 starting from reset default 0.
- REQ-033: RR_MODE=0, HBUSREQx=4'b1010 -> HGRANTx=4'b0010 persistently; drop bit 1 -> 4'b1000 on the next cycle.
- REQ-034: Master 2 granted with HLOCKx[2]=1 and master 3 requesting for 5 cycles -> HGRANTx stays 4'b0100 and HMASTLOCK=1; releasing the lock -> master 3 granted on the next cycle.
- REQ-035: HMASTER=1, HRESP=2'b11 with HREADY=0 -> master 1 masked and not granted while requesting; pulse HSPLIT[1] -> master 1 becomes eligible on the following cycle.
- REQ-036: HBUSREQx=0 with DEFAULT_MASTER=2 -> HGRANTx=4'b0100; HRESET asserted mid-lock -> outputs return to REQ-028 values on the next edge.
- REQ-037: All scenarios: an assertion SHALL check that HGRANTx is one-hot on every cycle and that HGRANTx is stable whenever HREADY=0.
